// File: rtl/map_hub_sel.sv
// Registered mapper hub: picks one of NCH slot bundles by map_idx and sequences mapper changes (drain, reset, settle, switch).
// Optional MAP_HUB_LOCK_EN adds a map_lock input that freezes target changes while running.
module map_hub_sel #(
    parameter int NCH     = 16,
    parameter int IDX_W   = 8,
    parameter int OUT_W   = 128,
    parameter int RST_LEN = 4,
    parameter int SETTLE  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IDX_W-1:0]         map_idx,
    input  logic [NCH*IDX_W-1:0]     slot_tag,
    input  logic [NCH*OUT_W-1:0]     slot_out,
    input  logic                     bus_idle,
`ifdef MAP_HUB_LOCK_EN
    input  logic                     map_lock,
`endif
    output logic [OUT_W-1:0]         map_out,
    output logic [NCH-1:0]           slot_rst,
    output logic [$clog2(NCH)-1:0]   cur_slot,
    output logic                     hit,
    output logic                     busy
);

    localparam int SW      = $clog2(NCH);
    localparam int CNT_MAX = (RST_LEN > SETTLE) ? RST_LEN : SETTLE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_RESET,
        ST_SETTLE,
        ST_SWITCH
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [SW-1:0]    nxt_slot;
    logic             nxt_hit;
    logic [SW-1:0]    tgt_slot;
    logic             tgt_hit;
    logic             lock;

`ifdef MAP_HUB_LOCK_EN
    assign lock = map_lock;
`else
    assign lock = 1'b0;
`endif

    // Descending scan so the lowest matching slot is the one left standing.
    always_comb begin
        tgt_slot = '0;
        tgt_hit  = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (slot_tag[k*IDX_W +: IDX_W] == map_idx) begin
                tgt_slot = SW'(k);
                tgt_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            cnt      <= '0;
            nxt_slot <= '0;
            nxt_hit  <= 1'b0;
            cur_slot <= '0;
            hit      <= 1'b0;
            map_out  <= '0;
        end else begin
            state <= state_n;
            case (state)
                ST_RUN: begin
                    if (state_n == ST_DRAIN) begin
                        nxt_slot <= tgt_slot;
                        nxt_hit  <= tgt_hit;
                    end
                end
                ST_DRAIN: begin
                    if (state_n != ST_RUN) begin
                        nxt_slot <= tgt_slot;
                        nxt_hit  <= tgt_hit;
                    end
                    if (state_n == ST_RESET) begin
                        cnt <= CNT_W'(RST_LEN - 1);
                    end
                end
                ST_RESET: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (SETTLE > 0) begin
                        cnt <= CNT_W'(SETTLE - 1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SWITCH: begin
                    cur_slot <= nxt_slot;
                    hit      <= nxt_hit;
                end
                default: ;
            endcase
            // The switch cycle already loads the incoming bundle so no stale slot leaks out.
            case (state)
                ST_RESET, ST_SETTLE: map_out <= '0;
                ST_SWITCH:           map_out <= slot_out[nxt_slot*OUT_W +: OUT_W];
                default:             map_out <= slot_out[cur_slot*OUT_W +: OUT_W];
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_RUN: begin
                if (!lock && (tgt_slot != cur_slot)) state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (tgt_slot == cur_slot) begin
                    state_n = ST_RUN;
                end else if ((tgt_slot == nxt_slot) && bus_idle) begin
                    state_n = ST_RESET;
                end
            end
            ST_RESET: begin
                if (cnt == '0) state_n = (SETTLE == 0) ? ST_SWITCH : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt == '0) state_n = ST_SWITCH;
            end
            ST_SWITCH: state_n = ST_RUN;
            default:   state_n = ST_RUN;
        endcase
    end

    always_comb begin
        busy     = (state != ST_RUN);
        slot_rst = '0;
        if (state == ST_RESET) slot_rst[nxt_slot] = 1'b1;
    end

endmodule

// File: tb/tb_map_hub_sel.sv
// Self-checking bench for map_hub_sel: cycle model based on sequence age, directed scenarios plus randomized traffic.
// Define MAP_HUB_LOCK_EN for both files to exercise the map_lock input.
module tb_map_hub_sel;

    localparam int NCH     = 16;
    localparam int IDX_W   = 8;
    localparam int OUT_W   = 128;
    localparam int RST_LEN = 4;
    localparam int SETTLE  = 2;
    localparam int SW      = $clog2(NCH);
    localparam int SEQ_LEN = RST_LEN + SETTLE + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [IDX_W-1:0]     map_idx = 8'd99;
    logic                 bus_idle = 1'b1;
    logic                 map_lock = 1'b0;
    logic [IDX_W-1:0]     tags [NCH];
    logic [OUT_W-1:0]     outs [NCH];
    logic [NCH*IDX_W-1:0] slot_tag;
    logic [NCH*OUT_W-1:0] slot_out;
    logic [OUT_W-1:0]     map_out;
    logic [NCH-1:0]       slot_rst;
    logic [SW-1:0]        cur_slot;
    logic                 hit;
    logic                 busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        slot_tag = '0;
        slot_out = '0;
        for (int k = 0; k < NCH; k++) begin
            slot_tag[k*IDX_W +: IDX_W] = tags[k];
            slot_out[k*OUT_W +: OUT_W] = outs[k];
        end
    end

    map_hub_sel #(
        .NCH(NCH), .IDX_W(IDX_W), .OUT_W(OUT_W), .RST_LEN(RST_LEN), .SETTLE(SETTLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .map_idx  (map_idx),
        .slot_tag (slot_tag),
        .slot_out (slot_out),
        .bus_idle (bus_idle),
`ifdef MAP_HUB_LOCK_EN
        .map_lock (map_lock),
`endif
        .map_out  (map_out),
        .slot_rst (slot_rst),
        .cur_slot (cur_slot),
        .hit      (hit),
        .busy     (busy)
    );

    task automatic checkOutput(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [IDX_W-1:0] idx, input logic idle);
        @(posedge clk);
        #2;
        rst      = r;
        map_idx  = idx;
        bus_idle = idle;
    endtask

    function automatic logic [OUT_W-1:0] randBundle();
        return {$urandom, $urandom, $urandom, $urandom} | 128'd1;
    endfunction

    function automatic void lookup(input logic [IDX_W-1:0] idx, output int s, output bit h);
        s = 0;
        h = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (!h && tags[k] == idx) begin
                s = k;
                h = 1'b1;
            end
        end
    endfunction

    // Reference: a switch is a drain phase followed by SEQ_LEN cycles counted by age.
    int             m_cur, m_nxt, m_age;
    bit             m_hit, m_nxt_hit, m_drain;
    logic [OUT_W-1:0] m_out;
    bit             model_ok = 1'b0;

    always @(posedge clk) begin : model
        int t;
        bit th;
        if (rst) begin
            m_cur = 0; m_hit = 0; m_drain = 0; m_nxt = 0; m_nxt_hit = 0;
            m_age = -1; m_out = '0; model_ok = 1'b1;
        end else if (model_ok) begin
            lookup(map_idx, t, th);
            if (m_age >= 0 && m_age < SEQ_LEN - 1) m_out = '0;
            else if (m_age == SEQ_LEN - 1)         m_out = outs[m_nxt];
            else                                   m_out = outs[m_cur];
            if (m_age >= 0) begin
                if (m_age == SEQ_LEN - 1) begin
                    m_cur = m_nxt;
                    m_hit = m_nxt_hit;
                    m_age = -1;
                end else begin
                    m_age++;
                end
            end else if (m_drain) begin
                if (t == m_cur) begin
                    m_drain = 0;
                end else begin
                    if (t == m_nxt && bus_idle) begin
                        m_drain = 0;
                        m_age   = 0;
                    end
                    m_nxt     = t;
                    m_nxt_hit = th;
                end
            end else if (!map_lock && t != m_cur) begin
                m_drain   = 1;
                m_nxt     = t;
                m_nxt_hit = th;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            logic [NCH-1:0] exp_rst;
            exp_rst = (m_age >= 0 && m_age < RST_LEN) ? (NCH'(1) << m_nxt) : '0;
            checkOutput("cur_slot", OUT_W'(cur_slot), OUT_W'(m_cur));
            checkOutput("hit", OUT_W'(hit), OUT_W'(m_hit));
            checkOutput("busy", OUT_W'(busy), OUT_W'(m_drain || m_age >= 0));
            checkOutput("slot_rst", OUT_W'(slot_rst), OUT_W'(exp_rst));
            checkOutput("map_out", map_out, m_out);
        end
    end

    task automatic waitIdle(input string name);
        bit done = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput(name, OUT_W'(done), OUT_W'(1));
    endtask

    initial begin : watchdog
        #1000000;
        n_bad++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : stim
        logic [IDX_W-1:0] sel [8];
        int rst_cnt, zero_cnt;
        bit seen, done;
        sel = '{8'd4, 8'd12, 8'd99, 8'd100, 8'd101, 8'd102, 8'd104, 8'd115};
        for (int k = 0; k < NCH; k++) begin
            tags[k] = IDX_W'(100 + k);
            outs[k] = randBundle();
        end
        tags[5] = 8'd4;
        tags[3] = 8'd12;
        tags[7] = 8'd12;

        // Reset held for three edges, then released.
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_cur_slot", OUT_W'(cur_slot), '0);
        checkOutput("rst_hit", OUT_W'(hit), '0);
        checkOutput("rst_busy", OUT_W'(busy), '0);
        checkOutput("rst_slot_rst", OUT_W'(slot_rst), '0);
        checkOutput("rst_map_out", map_out, '0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_map_out_slot0", map_out, outs[0]);

        // Full switch to slot 5 with the bus idle.
        applyStimulus(1'b0, 8'd4, 1'b1);
        rst_cnt = 0; zero_cnt = 0; seen = 0; done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (slot_rst == 16'h0020) rst_cnt++;
            if (map_out == '0) zero_cnt++;
            if (busy) seen = 1'b1;
            else if (seen) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("sw5_done", OUT_W'(done), OUT_W'(1));
        checkOutput("sw5_slot_rst_cycles", OUT_W'(rst_cnt), OUT_W'(4));
        checkOutput("sw5_zero_cycles", OUT_W'(zero_cnt), OUT_W'(6));
        checkOutput("sw5_cur_slot", OUT_W'(cur_slot), OUT_W'(5));
        checkOutput("sw5_hit", OUT_W'(hit), OUT_W'(1));

        // Busy bus holds the sequence in drain; slot 5 keeps driving.
        applyStimulus(1'b0, 8'd99, 1'b0);
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("drain_busy", OUT_W'(busy), OUT_W'(1));
            checkOutput("drain_slot_rst", OUT_W'(slot_rst), '0);
            checkOutput("drain_map_out", map_out, outs[5]);
        end
        applyStimulus(1'b0, 8'd99, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("drain_release_rst", OUT_W'(slot_rst), OUT_W'(16'h0001));
        waitIdle("fallback_done");
        checkOutput("fallback_cur", OUT_W'(cur_slot), '0);
        checkOutput("fallback_hit", OUT_W'(hit), '0);

        // Duplicate tag 12 in slots 3 and 7: lowest wins.
        applyStimulus(1'b0, 8'd12, 1'b1);
        waitIdle("dup_done");
        checkOutput("dup_cur", OUT_W'(cur_slot), OUT_W'(3));
        checkOutput("dup_hit", OUT_W'(hit), OUT_W'(1));

        // Reset landing in the middle of the slot reset phase.
        applyStimulus(1'b0, 8'd4, 1'b1);
        done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (slot_rst != '0) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("midrst_reached", OUT_W'(done), OUT_W'(1));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_slot_rst", OUT_W'(slot_rst), '0);
        checkOutput("midrst_cur", OUT_W'(cur_slot), '0);
        checkOutput("midrst_busy", OUT_W'(busy), '0);
        applyStimulus(1'b0, 8'd4, 1'b1);
        waitIdle("midrst_recover");
        checkOutput("midrst_recover_cur", OUT_W'(cur_slot), OUT_W'(5));

`ifdef MAP_HUB_LOCK_EN
        @(posedge clk);
        #2 map_lock = 1'b1;
        map_idx = 8'd12;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        checkOutput("lock_no_busy", OUT_W'(seen), '0);
        @(posedge clk);
        #2 map_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("unlock_busy", OUT_W'(busy), OUT_W'(1));
        waitIdle("unlock_done");
        checkOutput("unlock_cur", OUT_W'(cur_slot), OUT_W'(3));
`endif

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [IDX_W-1:0] idx;
            idx = ($urandom_range(0, 7) == 0) ? sel[$urandom_range(0, 7)] : map_idx;
            applyStimulus($urandom_range(0, 199) == 0, idx, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) outs[$urandom_range(0, NCH - 1)] = randBundle();
`ifdef MAP_HUB_LOCK_EN
            if ($urandom_range(0, 15) == 0) map_lock = ~map_lock;
`endif
        end
        applyStimulus(1'b0, map_idx, 1'b1);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
